gray_seq_ctrl: RTL and testbench

Sequencer that drives the binary-to-Gray datapath. It walks a binary counter up or down from a programmed start value for a programmed number of steps. It emits each Gray-coded value on a valid/ready stream. Consumers are Gray-coded position and pointer logic that need single-bit-change stepping with backpressure.

---
 rtl/gray_seq_ctrl.sv | 113 +++++++++++
 tb/tb_gray_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: walks a binary counter up or down from a programmed start value
// for a programmed number of steps. Each value is presented in Gray code on a
// valid/ready stream, so every accepted code differs from the previous one in
// exactly one bit.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         pulse that begins a sequence; sampled only while idle
//   up            direction latched at start (1 = increment, 0 = decrement)
//   start_val     binary start value latched at start
//   count         number of codes to emit, latched at start (0 gives done only)
//   abort         ends an active sequence without a done pulse
//   out_ready     consumer accepts the current code
//   out_valid     gray_out/bin_out hold a valid code
//   gray_out      Gray code of the binary counter register
//   bin_out       binary counter register
//   busy          high while a sequence is running
//   done          one-cycle pulse when a sequence completes normally
//   wrap          one-cycle pulse in the cycle a wrapped value first appears
module gray_seq_ctrl #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             up,
    input  logic [WIDTH-1:0] start_val,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [CNT_W-1:0] remaining;
    logic             dir;

    // Gray code is decoded from the counter register alone, so it changes only
    // when bin changes and inherits bin's hold behaviour under backpressure.
    assign gray_out = bin ^ (bin >> 1);
    assign bin_out  = bin;

    // Sequencer: state, counter and all status outputs in one registered block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin       <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            done <= 1'b0;
            wrap <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (count != '0) begin
                        bin       <= start_val;
                        remaining <= count;
                        dir       <= up;
                        state     <= RUN;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        // Empty sequence completes immediately.
                        done <= 1'b1;
                    end
                end
            end else begin
                // out_valid is always high in RUN, so out_ready alone marks a
                // transfer. Abort takes priority over any same-cycle transfer.
                if (abort) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end else if (out_ready) begin
                    if (remaining == CNT_W'(1)) begin
                        // Last code accepted: bin keeps the last emitted value.
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                        if (dir) begin
                            bin  <= bin + WIDTH'(1);
                            wrap <= (bin == '1);
                        end else begin
                            bin  <= bin - WIDTH'(1);
                            wrap <= (bin == '0);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (WIDTH=3). Inputs are driven and
// outputs sampled on the falling clock edge, half a cycle from the active edge.
module tb_gray_seq_ctrl;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned CNT_W = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             up;
    logic [WIDTH-1:0] start_val;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             done;
    logic             wrap;

    int n_cmp = 0;
    int n_err = 0;
    int xfers = 0;
    int dones = 0;

    gray_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .up       (up),
        .start_val(start_val),
        .count    (count),
        .abort    (abort),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted transfers and done pulses as seen at the active edge.
    always @(posedge clk) begin
        if (out_valid && out_ready) xfers++;
        if (done) dones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a one-cycle start; returns at the sample point of cycle 1.
    task automatic pulse_start(input logic [WIDTH-1:0] sv, input logic u, input logic [CNT_W-1:0] c);
        start_val = sv;
        up        = u;
        count     = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Check one presented code, then advance a cycle.
    task automatic expect_code(input string tag, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] g, input logic w);
        chk({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
        chk({tag, ".busy"},  32'(busy),      32'(1'b1));
        chk({tag, ".bin"},   32'(bin_out),   32'(b));
        chk({tag, ".gray"},  32'(gray_out),  32'(g));
        chk({tag, ".wrap"},  32'(wrap),      32'(w));
        chk({tag, ".done"},  32'(done),      32'(1'b0));
        step();
    endtask

    // Check the completion cycle and that done lasts exactly one cycle.
    task automatic expect_done(input string tag, input logic [WIDTH-1:0] b);
        chk({tag, ".valid"}, 32'(out_valid), 32'(1'b0));
        chk({tag, ".busy"},  32'(busy),      32'(1'b0));
        chk({tag, ".done"},  32'(done),      32'(1'b1));
        chk({tag, ".wrap"},  32'(wrap),      32'(1'b0));
        chk({tag, ".bin"},   32'(bin_out),   32'(b));
        step();
        chk({tag, ".done_low"}, 32'(done),   32'(1'b0));
    endtask

    task automatic expect_idle_zero(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(1'b0));
        chk({tag, ".busy"},  32'(busy),      32'(1'b0));
        chk({tag, ".done"},  32'(done),      32'(1'b0));
        chk({tag, ".wrap"},  32'(wrap),      32'(1'b0));
        chk({tag, ".bin"},   32'(bin_out),   32'(3'b000));
        chk({tag, ".gray"},  32'(gray_out),  32'(3'b000));
    endtask

    initial begin
        int x0;
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        up        = 1'b0;
        start_val = '0;
        count     = '0;
        abort     = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #2;
        expect_idle_zero("rst");
        step();
        expect_idle_zero("rst_edge");
        rst_n = 1'b1;
        step();

        // Abort while idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_idle_zero("abort_idle");

        // 1: full up count from 0, no wrap.
        pulse_start(3'd0, 1'b1, 4'd8);
        expect_code("t1c1", 3'd0, 3'b000, 1'b0);
        expect_code("t1c2", 3'd1, 3'b001, 1'b0);
        expect_code("t1c3", 3'd2, 3'b011, 1'b0);
        expect_code("t1c4", 3'd3, 3'b010, 1'b0);
        expect_code("t1c5", 3'd4, 3'b110, 1'b0);
        expect_code("t1c6", 3'd5, 3'b111, 1'b0);
        expect_code("t1c7", 3'd6, 3'b101, 1'b0);
        expect_code("t1c8", 3'd7, 3'b100, 1'b0);
        expect_done("t1done", 3'd7);

        // 2: up across the wrap.
        pulse_start(3'd6, 1'b1, 4'd4);
        expect_code("t2c1", 3'd6, 3'b101, 1'b0);
        expect_code("t2c2", 3'd7, 3'b100, 1'b0);
        expect_code("t2c3", 3'd0, 3'b000, 1'b1);
        expect_code("t2c4", 3'd1, 3'b001, 1'b0);
        expect_done("t2done", 3'd1);

        // 3: down across the wrap.
        pulse_start(3'd1, 1'b0, 4'd3);
        expect_code("t3c1", 3'd1, 3'b001, 1'b0);
        expect_code("t3c2", 3'd0, 3'b000, 1'b0);
        expect_code("t3c3", 3'd7, 3'b100, 1'b1);
        expect_done("t3done", 3'd7);

        // 4: backpressure for 3 cycles on the 2nd code.
        x0 = xfers;
        d0 = dones;
        pulse_start(3'd2, 1'b1, 4'd5);
        expect_code("t4c1", 3'd2, 3'b011, 1'b0);
        out_ready = 1'b0;
        expect_code("t4s1", 3'd3, 3'b010, 1'b0);
        expect_code("t4s2", 3'd3, 3'b010, 1'b0);
        expect_code("t4s3", 3'd3, 3'b010, 1'b0);
        out_ready = 1'b1;
        expect_code("t4c2", 3'd3, 3'b010, 1'b0);
        expect_code("t4c3", 3'd4, 3'b110, 1'b0);
        expect_code("t4c4", 3'd5, 3'b111, 1'b0);
        expect_code("t4c5", 3'd6, 3'b101, 1'b0);
        expect_done("t4done", 3'd6);
        chk("t4.xfers", 32'(xfers - x0), 32'd5);
        chk("t4.dones", 32'(dones - d0), 32'd1);

        // 5a: abort on the 3rd code with a same-cycle transfer.
        pulse_start(3'd0, 1'b1, 4'd8);
        expect_code("t5c1", 3'd0, 3'b000, 1'b0);
        expect_code("t5c2", 3'd1, 3'b001, 1'b0);
        abort = 1'b1;
        expect_code("t5c3", 3'd2, 3'b011, 1'b0);
        abort = 1'b0;
        chk("t5ab.valid", 32'(out_valid), 32'(1'b0));
        chk("t5ab.busy",  32'(busy),      32'(1'b0));
        chk("t5ab.done",  32'(done),      32'(1'b0));
        chk("t5ab.bin",   32'(bin_out),   32'(3'd2));
        chk("t5ab.gray",  32'(gray_out),  32'(3'b011));
        step();
        chk("t5ab.done2", 32'(done),      32'(1'b0));
        chk("t5ab.bin2",  32'(bin_out),   32'(3'd2));
        // New start after abort.
        pulse_start(3'd5, 1'b0, 4'd2);
        expect_code("t5n1", 3'd5, 3'b111, 1'b0);
        expect_code("t5n2", 3'd4, 3'b110, 1'b0);
        expect_done("t5ndone", 3'd4);

        // 5b: asynchronous reset mid-run.
        pulse_start(3'd3, 1'b1, 4'd8);
        expect_code("t5r1", 3'd3, 3'b010, 1'b0);
        chk("t5r2.gray", 32'(gray_out), 32'(3'b110));
        #2 rst_n = 1'b0;
        #1;
        expect_idle_zero("t5rst");
        #1 rst_n = 1'b1;
        step();
        expect_idle_zero("t5rst_after");

        // 6a: count 0 gives a done pulse and no valid.
        pulse_start(3'd4, 1'b1, 4'd0);
        chk("t6z.done",  32'(done),      32'(1'b1));
        chk("t6z.valid", 32'(out_valid), 32'(1'b0));
        chk("t6z.busy",  32'(busy),      32'(1'b0));
        step();
        chk("t6z.done2", 32'(done),      32'(1'b0));
        chk("t6z.valid2", 32'(out_valid), 32'(1'b0));

        // 6b: start during RUN is ignored.
        pulse_start(3'd0, 1'b1, 4'd3);
        expect_code("t6c1", 3'd0, 3'b000, 1'b0);
        start_val = 3'd5;
        up        = 1'b0;
        count     = 4'd8;
        start     = 1'b1;
        expect_code("t6c2", 3'd1, 3'b001, 1'b0);
        start     = 1'b0;
        expect_code("t6c3", 3'd2, 3'b011, 1'b0);
        expect_done("t6done", 3'd2);
        chk("t6.idle_valid", 32'(out_valid), 32'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
